// File: rtl/aes_sbox_share_checker.sv
// Golden-model checker for a masked, pipelined AES S-box: recombines input/output shares,
// compares against an unmasked table after a fixed latency and tracks mismatches per run.
module aes_sbox_share_checker #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4,
    parameter int NVEC    = 65536,
    parameter int CNT_W   = 17
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  StartxSI,
    input  logic                  InValidxSI,
    input  logic [8*SHARES-1:0]   _XxDI,
    input  logic [8*SHARES-1:0]   _QxDI,
    output logic                  BusyxSO,
    output logic                  DonexSO,
    output logic                  FailxSO,
    output logic [CNT_W-1:0]      ErrCntxDO,
    output logic [CNT_W-1:0]      VecCntxDO,
    output logic [7:0]            FailXxDO,
    output logic [7:0]            FailQxDO
);

    localparam int DW = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] NVEC_C = CNT_W'(NVEC);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NVEC - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t stateP, stateN;

    logic [7:0]       xU, qU, eU;
    logic             accept, startRun, tapVld, mismatch;
    logic [CNT_W-1:0] accCnt, vecCnt, errCnt;
    logic [DW-1:0]    drainCnt;
    logic             failReg;
    logic [7:0]       failX, failQ;

    logic [LATENCY-1:0] vldPipe;
    logic [7:0]         ePipe [LATENCY];
    logic [7:0]         xPipe [LATENCY];

    always_comb begin
        xU = '0;
        qU = '0;
        for (int i = 0; i < SHARES; i++) begin
            xU ^= _XxDI[8*i +: 8];
            qU ^= _QxDI[8*i +: 8];
        end
    end

    assign eU       = SBOX[xU];
    assign accept   = InValidxSI && (stateP == RUN) && (accCnt < NVEC_C);
    assign startRun = StartxSI && ((stateP == IDLE) || (stateP == DONE));
    assign tapVld   = vldPipe[LATENCY-1];
    assign mismatch = tapVld && (qU != ePipe[LATENCY-1]);

    // Expectation pipe: stage LATENCY-1 is aligned with the sbox output shares.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI || startRun) begin
            vldPipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                ePipe[i] <= '0;
                xPipe[i] <= '0;
            end
        end else begin
            for (int i = LATENCY-1; i > 0; i--) begin
                vldPipe[i] <= vldPipe[i-1];
                ePipe[i]   <= ePipe[i-1];
                xPipe[i]   <= xPipe[i-1];
            end
            vldPipe[0] <= accept;
            ePipe[0]   <= eU;
            xPipe[0]   <= xU;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI || startRun) begin
            accCnt  <= '0;
            vecCnt  <= '0;
            errCnt  <= '0;
            failReg <= 1'b0;
            failX   <= '0;
            failQ   <= '0;
        end else begin
            if (accept) accCnt <= accCnt + 1'b1;
            if (tapVld) vecCnt <= vecCnt + 1'b1;
            if (mismatch) begin
                if (errCnt != '1) errCnt <= errCnt + 1'b1;
                failReg <= 1'b1;
                if (!failReg) begin
                    failX <= xPipe[LATENCY-1];
                    failQ <= qU;
                end
            end
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            stateP   <= IDLE;
            drainCnt <= '0;
        end else begin
            stateP <= stateN;
            if (stateP == RUN && stateN == DRAIN) drainCnt <= DW'(LATENCY);
            else if (stateP == DRAIN)              drainCnt <= drainCnt - 1'b1;
        end
    end

    // DRAIN leaves on the cycle the down-counter reaches zero, i.e. after the last tap compare.
    always_comb begin
        stateN = stateP;
        case (stateP)
            IDLE:    if (StartxSI) stateN = RUN;
            RUN:     if (accept && accCnt == LAST_C) stateN = DRAIN;
            DRAIN:   if (drainCnt <= DW'(1)) stateN = DONE;
            DONE:    if (StartxSI) stateN = RUN;
            default: stateN = IDLE;
        endcase
    end

    assign BusyxSO   = (stateP == RUN) || (stateP == DRAIN);
    assign DonexSO   = (stateP == DONE);
    assign FailxSO   = failReg;
    assign ErrCntxDO = errCnt;
    assign VecCntxDO = vecCnt;
    assign FailXxDO  = failX;
    assign FailQxDO  = failQ;

endmodule

// File: tb/tb_aes_sbox_share_checker.sv
// Directed bench for aes_sbox_share_checker: a latency-matched share model feeds Q,
// small NVEC keeps full runs, gaps, restarts and mid-run reset short.
module tb_aes_sbox_share_checker;

    localparam int SH  = 2;
    localparam int LAT = 4;
    localparam int NV  = 16;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          rstN, start, inValid;
    logic [15:0]   xSh, qSh, qWant;
    logic          busy, done, fail;
    logic [CW-1:0] errCnt, vecCnt;
    logic [7:0]    failX, failQ;
    logic [15:0]   qPipe [LAT];

    int checks   = 0;
    int failures = 0;

    aes_sbox_share_checker #(.SHARES(SH), .LATENCY(LAT), .NVEC(NV), .CNT_W(CW)) dut (
        .ClkxCI(clk), .RstxBI(rstN), .StartxSI(start), .InValidxSI(inValid),
        ._XxDI(xSh), ._QxDI(qSh),
        .BusyxSO(busy), .DonexSO(done), .FailxSO(fail),
        .ErrCntxDO(errCnt), .VecCntxDO(vecCnt), .FailXxDO(failX), .FailQxDO(failQ)
    );

    always #5 clk = ~clk;

    // Stand-in for the masked sbox: delivers the requested output shares LAT cycles later.
    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) qPipe[i] <= qPipe[i-1];
        qPipe[0] <= qWant;
    end
    assign qSh = qPipe[LAT-1];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkAll(input string nm, input int v, input int e, input int f,
                          input int fx, input int fq);
        chk({nm, ".vec"},   int'(vecCnt), v);
        chk({nm, ".err"},   int'(errCnt), e);
        chk({nm, ".fail"},  int'(fail),   f);
        chk({nm, ".failX"}, int'(failX),  fx);
        chk({nm, ".failQ"}, int'(failQ),  fq);
    endtask

    // One cycle of stimulus with fresh masks on both the input and output shares.
    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] q);
        logic [7:0] m, n;
        m = 8'($urandom);
        n = 8'($urandom);
        inValid = v;
        xSh     = {m, x ^ m};
        qWant   = {n, q ^ n};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'h00);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] x, q;
        int vec, err, f, fx, fq;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] kpX [8];
    logic [7:0] kpS [8];

    initial begin
        int acc, cyc, n;
        logic [7:0] x, q;

        tbl[0] = '{x:8'h00, q:8'h63, vec:1, err:0, f:0, fx:8'h00, fq:8'h00};
        tbl[1] = '{x:8'h01, q:8'h7c, vec:2, err:0, f:0, fx:8'h00, fq:8'h00};
        tbl[2] = '{x:8'h53, q:8'hed, vec:3, err:0, f:0, fx:8'h00, fq:8'h00};
        tbl[3] = '{x:8'h01, q:8'h7c, vec:4, err:0, f:0, fx:8'h00, fq:8'h00};
        tbl[4] = '{x:8'h53, q:8'hec, vec:5, err:1, f:1, fx:8'h53, fq:8'hec};
        tbl[5] = '{x:8'hff, q:8'h16, vec:6, err:1, f:1, fx:8'h53, fq:8'hec};
        tbl[6] = '{x:8'h10, q:8'h00, vec:7, err:2, f:1, fx:8'h53, fq:8'hec};
        kpX = '{8'h00, 8'h01, 8'h53, 8'h10, 8'h20, 8'hff, 8'h5a, 8'h80};
        kpS = '{8'h63, 8'h7c, 8'hed, 8'hca, 8'hb7, 8'h16, 8'hbe, 8'hcd};

        rstN = 1'b0; start = 1'b0; inValid = 1'b0; xSh = '0; qWant = '0;
        repeat (3) @(negedge clk);
        chkAll("reset", 0, 0, 0, 0, 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        rstN = 1'b1;

        // Run 1: table of single vectors, each compared after the pipe latency.
        pulseStart();
        chk("run1.busy", int'(busy), 1);
        xSh = 16'h5a5a; inValid = 1'b1; qWant = 16'h0063;
        @(negedge clk);
        inValid = 1'b0;
        idle(LAT);
        chkAll("share5a5a", tbl[0].vec, tbl[0].err, tbl[0].f, tbl[0].fx, tbl[0].fq);
        for (int i = 1; i < 7; i++) begin
            drive(1'b1, tbl[i].x, tbl[i].q);
            idle(LAT);
            chkAll($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].err, tbl[i].f, tbl[i].fx, tbl[i].fq);
        end
        pulseStart();
        chk("startIgnored.vec", int'(vecCnt), 7);
        for (int i = 0; i < NV - 7; i++) drive(1'b1, kpX[i%8], kpS[i%8]);
        for (int k = 1; k <= LAT; k++) begin
            chk("drain.done", int'(done), 0);
            chk("drain.busy", int'(busy), 1);
            drive(1'b1, 8'h20, 8'h00);
        end
        chk("run1.done", int'(done), 1);
        chk("run1.busy", int'(busy), 0);
        chkAll("run1.end", NV, 2, 1, 8'h53, 8'hec);
        drive(1'b1, 8'h01, 8'h00);
        idle(LAT + 1);
        chk("doneHold.vec", int'(vecCnt), NV);
        chk("doneHold.done", int'(done), 1);

        // Run 2: restart from DONE, gap every 3rd cycle, two injected mismatches.
        pulseStart();
        chkAll("restart1", 0, 0, 0, 0, 0);
        chk("restart1.done", int'(done), 0);
        acc = 0; cyc = 0;
        while (acc < NV) begin
            if (cyc % 3 == 2) begin
                drive(1'b0, 8'($urandom), 8'h00);
            end else begin
                x = kpX[acc%8]; q = kpS[acc%8];
                if (acc == 3) begin x = 8'h10; q = 8'h11; end
                if (acc == 9) begin x = 8'h20; q = 8'h22; end
                drive(1'b1, x, q);
                acc++;
            end
            cyc++;
            chk("gaps.busy", int'(busy), 1);
        end
        n = 0;
        while (!done && n < 20) begin
            chk("wait.busy", int'(busy), 1);
            idle(1);
            n++;
        end
        chk("run2.doneLatency", n, LAT);
        chkAll("run2.end", NV, 2, 1, 8'h10, 8'h11);

        pulseStart();
        chkAll("restart2", 0, 0, 0, 0, 0);
        chk("restart2.busy", int'(busy), 1);

        // Run 3: reset mid-run with mismatching vectors still in flight.
        for (int i = 0; i < 10; i++) drive(1'b1, kpX[i%8], kpS[i%8]);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h53, 8'h00);
        rstN = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        rstN = 1'b1;
        chkAll("midReset", 0, 0, 0, 0, 0);
        chk("midReset.busy", int'(busy), 0);
        chk("midReset.done", int'(done), 0);
        drive(1'b1, 8'h01, 8'h00);
        drive(1'b1, 8'h02, 8'h00);
        idle(LAT + 2);
        chkAll("afterReset", 0, 0, 0, 0, 0);
        chk("afterReset.busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
